thor2022_prefix_collector: RTL and testbench

Fetch-to-decode stage that absorbs Thor2022 immediate-extension prefixes (EXI8/24/40/56 and their +1 forms, EXIM) in front of the instruction they modify. It accumulates the prefix constant bits into a width-parametrised extension register. It emits one registered packet per real instruction: the instruction, its start PC and the merged upper-immediate bits. This replaces the fixed single-xir/mir look-back with a stateful, multi-prefix, back-pressured stage.

---
 rtl/thor2022_pkg.sv | 36 +++
 rtl/thor2022_pfx_field.sv | 49 ++++
 rtl/thor2022_prefix_collector.sv | 161 ++++++++++++++++
 tb/tb_thor2022_prefix_collector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/thor2022_pkg.sv
// Shared opcodes, prefix-group state and decode helpers for the Thor2022 prefix collector.
// The accumulator is sized for the widest build (WID=128); narrower builds mask the top.
package thor2022_pkg;

  localparam int ACC_MAX = 104;  // ext bits [127:24]

  // Opcode lives in ir[8:1]; ir[0] selects the +1 form and doubles as the field LSB.
  localparam logic [7:0] OPC_EXI8  = 8'h50;
  localparam logic [7:0] OPC_EXI24 = 8'h51;
  localparam logic [7:0] OPC_EXI40 = 8'h52;
  localparam logic [7:0] OPC_EXI56 = 8'h53;
  localparam logic [7:0] OPC_EXIM  = 8'h54;

  localparam logic [ACC_MAX-1:0] X_MASK = {48'b0, {56{1'b1}}};
  localparam logic [ACC_MAX-1:0] M_MASK = {{48{1'b1}}, 56'b0};

  typedef enum logic {ST_IDLE, ST_PEND} pfx_state_e;

  typedef struct packed {
    logic [ACC_MAX-1:0] acc;
    logic               xseen;
    logic               mseen;
    logic [2:0]         cnt;
    logic [63:0]        grp_pc;
  } pfx_group_t;

  function automatic logic is_exix(input logic [7:0] opc);
    return (opc == OPC_EXI8) || (opc == OPC_EXI24) ||
           (opc == OPC_EXI40) || (opc == OPC_EXI56);
  endfunction

  function automatic logic is_prefix(input logic [7:0] opc);
    return is_exix(opc) || (opc == OPC_EXIM);
  endfunction

endpackage

// File: rtl/thor2022_pfx_field.sv
// Applies one prefix's constant field to an accumulator (extraction + sign extension).
// EXIM handling is present only when THOR_PFX_EXIM_EN is defined.
module thor2022_pfx_field
  import thor2022_pkg::*;
#(
  parameter int WID  = 128,
  parameter int IWID = 64
) (
  input  logic [IWID-1:0]    ir,
  input  logic [ACC_MAX-1:0] acc_i,
  input  logic               mseen_i,
  output logic [ACC_MAX-1:0] acc_o
);

  localparam int AW = WID - 24;
  localparam logic [ACC_MAX-1:0] W_MASK = {ACC_MAX{1'b1}} >> (ACC_MAX - AW);

  logic [7:0]         opc;
  logic [55:0]        xf;
  logic [ACC_MAX-1:0] xs;
  logic [ACC_MAX-1:0] xmask;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    opc = ir[8:1];
    case (opc)
      OPC_EXI8:  xf = {{48{ir[15]}}, ir[15:9], ir[0]};
      OPC_EXI24: xf = {{32{ir[31]}}, ir[31:9], ir[0]};
      OPC_EXI40: xf = {{16{ir[47]}}, ir[47:9], ir[0]};
      OPC_EXI56: xf = {ir[63:9], ir[0]};
      default:   xf = '0;
    endcase
    xs = {{48{xf[55]}}, xf};
    // An EXIM already in the group owns bits 80 and up; sign extension stops at 79.
    xmask = mseen_i ? X_MASK : '1;
    acc_o = acc_i;
    if (is_exix(opc)) begin
      acc_o = (acc_i & ~xmask) | (xs & xmask);
    end
`ifdef THOR_PFX_EXIM_EN
    else if (opc == OPC_EXIM) begin
      acc_o = (acc_i & ~M_MASK) | {ir[56:9], 56'b0};
    end
`else
`endif
    acc_o = acc_o & W_MASK;
  end

endmodule

// File: rtl/thor2022_prefix_collector.sv
// Fetch-to-decode stage folding Thor2022 EXIx/EXIM prefixes into one packet per instruction.
// Define THOR_PFX_EXIM_EN to accept EXIM; otherwise EXIM is reported as an illegal prefix.
module thor2022_prefix_collector
  import thor2022_pkg::*;
#(
  parameter int WID     = 128,
  parameter int IWID    = 64,
  parameter int MAX_PFX = 2
) (
  input  logic            rst_i,
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            in_v_i,
  output logic            in_rdy_o,
  input  logic [IWID-1:0] ir_i,
  input  logic [63:0]     pc_i,
  output logic            out_v_o,
  input  logic            out_rdy_i,
  output logic [IWID-1:0] ir_o,
  output logic [63:0]     pc_o,
  output logic [WID-25:0] ext_o,
  output logic            extx_v_o,
  output logic            extm_v_o,
  output logic            err_o,
  output logic [63:0]     err_pc_o
);

  localparam int AW = WID - 24;

`ifdef THOR_PFX_EXIM_EN
  if (WID < 81 || WID > 128) begin : g_bad_wid
    $error("thor2022_prefix_collector: WID must be 81..128 with EXIM enabled");
  end
`else
  if (WID < 64 || WID > 128) begin : g_bad_wid
    $error("thor2022_prefix_collector: WID must be 64..128");
  end
`endif
  if (MAX_PFX < 1 || MAX_PFX > 4) begin : g_bad_max
    $error("thor2022_prefix_collector: MAX_PFX must be 1..4");
  end

  pfx_state_e         state_q, state_n;
  pfx_group_t         grp_q, grp_n, base;
  logic [ACC_MAX-1:0] pf_acc;
  logic [7:0]         opc;
  logic               accept, pfx, exix, exim, drop, illegal, restart;
  logic               out_v_q, out_v_n, out_ld, err_q, err_n;
  logic [63:0]        err_pc_q, err_pc_n, out_pc_n, pc_q;
  logic [IWID-1:0]    ir_q;
  logic [AW-1:0]      ext_q;
  logic               extx_q;

  assign in_rdy_o = ~out_v_q | out_rdy_i;
  assign accept   = in_v_i & in_rdy_o;
  assign opc      = ir_i[8:1];
  assign pfx      = is_prefix(opc);
  assign exix     = is_exix(opc);
  assign exim     = (opc == OPC_EXIM);
`ifdef THOR_PFX_EXIM_EN
  assign drop     = 1'b0;
`else
  assign drop     = exim;
`endif
  assign illegal  = drop | ((state_q == ST_PEND) &
                    ((exix & grp_q.xseen) | (exim & grp_q.mseen) | (grp_q.cnt >= 3'(MAX_PFX))));
  // An illegal prefix throws the held group away and starts a fresh one.
  assign restart  = (state_q == ST_IDLE) | illegal;
  assign base     = restart ? '0 : grp_q;

  thor2022_pfx_field #(.WID(WID), .IWID(IWID)) u_field (
    .ir      (ir_i),
    .acc_i   (base.acc),
    .mseen_i (base.mseen),
    .acc_o   (pf_acc)
  );

  always_comb begin
    state_n  = state_q;
    grp_n    = grp_q;
    out_v_n  = out_v_q & ~out_rdy_i;
    out_ld   = 1'b0;
    out_pc_n = (state_q == ST_PEND) ? grp_q.grp_pc : pc_i;
    err_n    = 1'b0;
    err_pc_n = err_pc_q;
    if (flush_i) begin
      state_n = ST_IDLE;
      grp_n   = '0;
      out_v_n = 1'b0;
    end else if (accept) begin
      if (!pfx) begin
        out_ld  = 1'b1;
        out_v_n = 1'b1;
        grp_n   = '0;
        state_n = ST_IDLE;
      end else begin
        err_n = illegal;
        if (illegal) err_pc_n = pc_i;
        if (drop) begin
          grp_n   = '0;
          state_n = ST_IDLE;
        end else begin
          grp_n.acc    = pf_acc;
          grp_n.xseen  = base.xseen | exix;
          grp_n.mseen  = base.mseen | exim;
          grp_n.cnt    = base.cnt + 3'd1;
          grp_n.grp_pc = restart ? pc_i : grp_q.grp_pc;
          state_n      = ST_PEND;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      out_v_q  <= 1'b0;
      err_q    <= 1'b0;
      err_pc_q <= '0;
      // NOTE: the packet datapath is reset too, since the decoder sees it as zero after reset.
      ir_q     <= '0;
      pc_q     <= '0;
      ext_q    <= '0;
      extx_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      grp_q    <= grp_n;
      out_v_q  <= out_v_n;
      err_q    <= err_n;
      err_pc_q <= err_pc_n;
      if (out_ld) begin
        ir_q   <= ir_i;
        pc_q   <= out_pc_n;
        ext_q  <= grp_q.acc[AW-1:0];
        extx_q <= grp_q.xseen;
      end
    end
  end

`ifdef THOR_PFX_EXIM_EN
  logic extm_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)       extm_q <= 1'b0;
    else if (out_ld) extm_q <= grp_q.mseen;
  end
  assign extm_v_o = extm_q;
`else
  assign extm_v_o = 1'b0;
`endif

  assign out_v_o  = out_v_q;
  assign ir_o     = ir_q;
  assign pc_o     = pc_q;
  assign ext_o    = ext_q;
  assign extx_v_o = extx_q;
  assign err_o    = err_q;
  assign err_pc_o = err_pc_q;

endmodule

// File: tb/tb_thor2022_prefix_collector.sv
// Directed bench for thor2022_prefix_collector (WID=128); expectations follow THOR_PFX_EXIM_EN.
module tb_thor2022_prefix_collector;
  import thor2022_pkg::*;

  localparam logic [7:0] OPC_ADDI = 8'h04;
  localparam logic [7:0] OPC_LDO  = 8'h60;

  logic         clk = 1'b0;
  logic         rst, flush, in_v, in_rdy, out_v, out_rdy;
  logic [63:0]  ir, pc, ir_o, pc_o, err_pc;
  logic [103:0] ext;
  logic         extx_v, extm_v, err;

  int checks = 0;
  int errors = 0;

  logic [63:0]  i_a, i_b;
  logic [103:0] e_exp;

  thor2022_prefix_collector #(.WID(128), .IWID(64), .MAX_PFX(2)) dut (
    .rst_i     (rst),
    .clk_i     (clk),
    .flush_i   (flush),
    .in_v_i    (in_v),
    .in_rdy_o  (in_rdy),
    .ir_i      (ir),
    .pc_i      (pc),
    .out_v_o   (out_v),
    .out_rdy_i (out_rdy),
    .ir_o      (ir_o),
    .pc_o      (pc_o),
    .ext_o     (ext),
    .extx_v_o  (extx_v),
    .extm_v_o  (extm_v),
    .err_o     (err),
    .err_pc_o  (err_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_pfx(input logic [7:0] opc, input int n, input logic [55:0] f);
    logic [63:0] r;
    r = '0;
    r[8:1] = opc;
    r[0] = f[0];
    for (int i = 1; i < n; i++) r[8+i] = f[i];
    return r;
  endfunction

  function automatic logic [63:0] mk_exim(input logic [47:0] m);
    logic [63:0] r;
    r = '0;
    r[8:1] = OPC_EXIM;
    r[56:9] = m;
    return r;
  endfunction

  function automatic logic [63:0] mk_op(input logic [7:0] opc, input logic [15:0] tag);
    logic [63:0] r;
    r = '0;
    r[8:1] = opc;
    r[24:9] = tag;
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_v = 1'b0; out_rdy = 1'b1; ir = '0; pc = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_v", out_v, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_err", err, 0);
    check("rst_err_pc", err_pc, 0);
    check("rst_ext", ext, 0);
    check("rst_pc", pc_o, 0);
    check("rst_ir", ir_o, 0);
    check("rst_flags", {extx_v, extm_v}, 0);

    // EXI24 all-ones field, then ADDI: sign extends to bit 127.
    in_v = 1'b1; ir = mk_pfx(OPC_EXI24, 24, 56'hFFFFFF); pc = 64'h1000;
    tick();
    check("exi24_no_pkt", out_v, 0);
    i_a = mk_op(OPC_ADDI, 16'h1111);
    ir = i_a; pc = 64'h1008;
    tick();
    e_exp = '1;
    check("exi24_v", out_v, 1);
    check("exi24_ir", ir_o, i_a);
    check("exi24_pc", pc_o, 64'h1000);
    check("exi24_ext", ext, e_exp);
    check("exi24_flags", {extx_v, extm_v}, 2'b10);

    // Back-to-back plain instruction: one packet per cycle, no extension.
    i_b = mk_op(OPC_LDO, 16'h2222);
    ir = i_b; pc = 64'h1010;
    tick();
    check("plain_v", out_v, 1);
    check("plain_ir", ir_o, i_b);
    check("plain_pc", pc_o, 64'h1010);
    check("plain_ext", ext, 0);
    check("plain_xv", extx_v, 0);

`ifdef THOR_PFX_EXIM_EN
    ir = mk_pfx(OPC_EXI8, 8, 56'h5A); pc = 64'h2000;
    tick();
    check("m_no_pkt0", out_v, 0);
    ir = mk_exim(48'h123456789ABC); pc = 64'h2008;
    tick();
    check("m_no_pkt1", out_v, 0);
    check("m_no_err", err, 0);
    i_a = mk_op(OPC_LDO, 16'h3333);
    ir = i_a; pc = 64'h2010;
    tick();
    e_exp = {48'h123456789ABC, 48'h0, 8'h5A};
    check("m_v", out_v, 1);
    check("m_pc", pc_o, 64'h2000);
    check("m_ext", ext, e_exp);
    check("m_flags", {extx_v, extm_v}, 2'b11);
`else
    ir = mk_exim(48'h123456789ABC); pc = 64'h2000;
    tick();
    check("m_err", err, 1);
    check("m_err_pc", err_pc, 64'h2000);
    check("m_no_pkt", out_v, 0);
    i_a = mk_op(OPC_ADDI, 16'h3333);
    ir = i_a; pc = 64'h2008;
    tick();
    check("m_err_pulse", err, 0);
    check("m_v", out_v, 1);
    check("m_pc", pc_o, 64'h2008);
    check("m_ext", ext, 0);
    check("m_flags", {extx_v, extm_v}, 2'b00);
`endif

    // Two EXI8 in a row: error on the second, which starts a new group.
    ir = mk_pfx(OPC_EXI8, 8, 56'h81); pc = 64'h3000;
    tick();
    check("dup_no_err", err, 0);
    ir = mk_pfx(OPC_EXI8, 8, 56'h7E); pc = 64'h3004;
    tick();
    check("dup_err", err, 1);
    check("dup_err_pc", err_pc, 64'h3004);
    i_a = mk_op(OPC_ADDI, 16'h4444);
    ir = i_a; pc = 64'h3008;
    tick();
    check("dup_err_pulse", err, 0);
    check("dup_v", out_v, 1);
    check("dup_pc", pc_o, 64'h3004);
    check("dup_ext", ext, 104'h7E);
    check("dup_xv", extx_v, 1);

    // Back-pressure: packet held stable for three cycles, then released.
    i_a = mk_op(OPC_ADDI, 16'h5555);
    ir = i_a; pc = 64'h4000;
    tick();
    check("bp_v", out_v, 1);
    out_rdy = 1'b0;
    i_b = mk_op(OPC_LDO, 16'h6666);
    ir = i_b; pc = 64'h4008;
    #1;
    check("bp_rdy0", in_rdy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_v", out_v, 1);
      check("bp_hold_pc", pc_o, 64'h4000);
      check("bp_hold_ir", ir_o, i_a);
      check("bp_hold_rdy", in_rdy, 0);
    end
    out_rdy = 1'b1;
    #1;
    check("bp_rdy1", in_rdy, 1);
    tick();
    check("bp_next_pc", pc_o, 64'h4008);
    check("bp_next_ir", ir_o, i_b);

    // Flush with a pending EXI40 and a simultaneous ADDI.
    ir = mk_pfx(OPC_EXI40, 40, 56'h80_0000_0001); pc = 64'h5000;
    tick();
    check("fl_no_pkt0", out_v, 0);
    flush = 1'b1;
    ir = mk_op(OPC_ADDI, 16'h7777); pc = 64'h5008;
    tick();
    check("fl_no_pkt1", out_v, 0);
    check("fl_no_err", err, 0);
    flush = 1'b0;
    i_a = mk_op(OPC_ADDI, 16'h8888);
    ir = i_a; pc = 64'h5010;
    tick();
    check("fl_after_v", out_v, 1);
    check("fl_after_pc", pc_o, 64'h5010);
    check("fl_after_ext", ext, 0);
    check("fl_after_xv", extx_v, 0);

    // Flush also drops a held packet.
    out_rdy = 1'b0; in_v = 1'b0; flush = 1'b1;
    tick();
    check("fl_clr_v", out_v, 0);
    flush = 1'b0; out_rdy = 1'b1;

    // Reset in the middle of a group.
    in_v = 1'b1; ir = mk_pfx(OPC_EXI24, 24, 56'h123456); pc = 64'h7000;
    tick();
    in_v = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_v", out_v, 0);
    in_v = 1'b1; i_a = mk_op(OPC_ADDI, 16'h9999);
    ir = i_a; pc = 64'h7008;
    tick();
    check("rmid_pc", pc_o, 64'h7008);
    check("rmid_ext", ext, 0);
    check("rmid_xv", extx_v, 0);
    in_v = 1'b0;
    tick();
    check("idle_v", out_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
